psum_collector: RTL and testbench
=================================

# psum_collector

Output-side counterpart of the systolic PE array. It receives the `result_out` streams leaving the bottom PE of each column and removes the per-column skew in weight-stationary (WS) mode. In output-stationary (OS) mode it tags the drained rows. Complete output rows go through a small FIFO and a valid/ready handshake to the output-buffer writer. The array cannot stall, so the collector never back-pressures the columns; it detects overflow and skew errors instead.

## Interface
- `PE_OUT_WIDTH`, 32, width of one column result (same as the PE result path)
- `NUM_COLS`, 4, number of array columns (≥2)
- `FIFO_DEPTH`, 4, output row FIFO entries (power of 2)
- `ROW_W`, 8, width of row count and row index
- `clk`  in  1  clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a collection job (honoured in IDLE only)
- `mode`  in  1  0 = WS, 1 = OS; sampled on `start`
- `num_rows`  in  ROW_W  rows expected in the job; sampled on `start`
- `col_data_in`  in  NUM_COLS*PE_OUT_WIDTH  column c at `[c*PE_OUT_WIDTH +: PE_OUT_WIDTH]`
- `col_valid_in`  in  NUM_COLS  per-column valid; skewed exactly like the data
- `out_data`  out  NUM_COLS*PE_OUT_WIDTH  aligned row, same column packing as `col_data_in`
- `out_row_idx`  out  ROW_W  row index of `out_data`
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts the head
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse at job completion
- `overflow`  out  1  sticky: a row was dropped because the FIFO was full
- `skew_err`  out  1  sticky: aligned valid bits disagreed

## Operation
- Reset and job state:
  - Every output resets to 0. Delay lines, FIFO, counters and state are cleared.
  - Reset mid-job aborts the job (state IDLE, FIFO empty). No `done` is issued.
- FSM:
  - IDLE → RUN on `start`. `start` latches `mode` and `num_rows`, clears `overflow`, `skew_err`, the delay lines and `rows_in`.
  - If `num_rows`=0, `start` goes IDLE → DONE directly.
  - RUN → DRAIN when `rows_in` reaches `num_rows` (takes effect the edge after the last counted row).
  - DRAIN → DONE when the FIFO is empty.
  - DONE → IDLE unconditionally; `done`=1 for that single cycle.
  - `start` outside IDLE is ignored.
- Deskew:
  - WS: column c passes through NUM_COLS−1−c register stages. Column NUM_COLS−1 has no delay.
  - OS: all columns bypass the delay lines (drain emits columns aligned).
  - In IDLE, DRAIN and DONE the inputs are ignored and the delay lines load zeros.
- Row detection, applied to the aligned valid vector V in RUN:
  - V all-ones: row event. It is written to the FIFO and `rows_in` increments.
  - V all-zeros: nothing happens.
  - Any other V: `skew_err` is set. No write, no count.
- Row index:
  - WS: `rows_in` (ascending 0..num_rows−1).
  - OS: num_rows−1−`rows_in` (descending; bottom PE drains first).
  - The index is stored in the FIFO alongside the data.
- FIFO:
  - A write with the FIFO full and no pop in the same cycle drops the row and sets `overflow`. The row is still counted.
  - Write and pop in the same cycle while full: both happen.
  - Write and pop in the same cycle while empty: the pop sees nothing; the write lands.
  - Pop occurs on `out_valid & out_ready`. `out_data`/`out_row_idx` hold steady while `out_valid & !out_ready`.
- Width rules: data passes unmodified with no arithmetic. `rows_in` wraps never because it stops at `num_rows`.

## Timing
- WS: column c of row i is presented at cycle s+i+c, where s is the row-0 column-0 arrival. The row becomes an `out_valid` head at s+i+NUM_COLS, provided the FIFO is empty.
- OS: an aligned row presented at cycle t is at the FIFO head at t+1.
- Full-throughput case: one row per cycle in, one per cycle out with `out_ready`=1, zero bubbles.
- `done` timing: `done` occurs 2 cycles after the last pop. The edge after the pop enters DONE… more precisely, the FIFO-empty check moves DRAIN→DONE, and `done` is high during DONE.
- `busy`: rises the cycle after `start` and falls the cycle after DONE.

## Test plan
- WS, NUM_COLS=4, num_rows=3, column c of row i at s+i+c with value 100i+c, `out_ready`=1 → `out_valid` at s+4..s+6. `out_data` columns are {100i+3, 100i+2, 100i+1, 100i}, `out_row_idx` 0,1,2. `done` is a single pulse. `overflow`=`skew_err`=0.
- OS, num_rows=4, aligned all-valid rows at s..s+3 with values 7,8,9,10 → heads at s+1..s+4 with `out_row_idx` 3,2,1,0.
- FIFO_DEPTH=4, `out_ready`=0, WS job of 6 rows → rows 4 and 5 dropped and `overflow`=1. Then `out_ready`=1 → exactly rows 0..3 popped in order, followed by `done`. The next `start` clears `overflow`.
- WS, column 2 valid one cycle late for row 1 → `skew_err`=1. Row 1 is not written; `rows_in` stays 1 and the job does not complete until a further valid row arrives.
- `reset` asserted in RUN with 2 rows in the FIFO → the next cycle has all outputs 0 and `busy`=0, and no `done` is issued. Then `start` with num_rows=0 → `busy`=1 and `done`=1 one cycle each, and no FIFO writes occur.

Source files
------------

// File: rtl/psum_collector.sv
// psum_collector: deskews per-column PE results into aligned rows (WS) or tags
// drained rows (OS), then queues complete rows in a small FIFO for the writer.
module psum_collector #(
  parameter int unsigned PE_OUT_WIDTH = 32,
  parameter int unsigned NUM_COLS     = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned ROW_W        = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             mode,
  input  logic [ROW_W-1:0]                 num_rows,
  input  logic [NUM_COLS*PE_OUT_WIDTH-1:0] col_data_in,
  input  logic [NUM_COLS-1:0]              col_valid_in,
  output logic [NUM_COLS*PE_OUT_WIDTH-1:0] out_data,
  output logic [ROW_W-1:0]                 out_row_idx,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             overflow,
  output logic                             skew_err
);

  localparam int unsigned DATA_W = NUM_COLS * PE_OUT_WIDTH;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ENT_W  = DATA_W + ROW_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               mode_q;
  logic [ROW_W-1:0]   num_rows_q;
  logic [ROW_W-1:0]   rows_in_q;
  logic               overflow_q;
  logic               skew_err_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];

  logic               run;
  logic               ws_run;
  logic [DATA_W-1:0]  al_data;
  logic [NUM_COLS-1:0] al_valid;

  assign run    = (state_q == S_RUN);
  assign ws_run = run && !mode_q;

  // Per-column deskew: column c is delayed NUM_COLS-1-c cycles in WS, bypassed in OS
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    localparam int unsigned D = NUM_COLS - 1 - c;
    logic [PE_OUT_WIDTH-1:0] in_d;
    logic                    in_v;
    assign in_d = col_data_in[c*PE_OUT_WIDTH +: PE_OUT_WIDTH];
    assign in_v = col_valid_in[c];

    if (D == 0) begin : g_nodly
      assign al_valid[c]                             = run & in_v;
      assign al_data[c*PE_OUT_WIDTH +: PE_OUT_WIDTH] = run ? in_d : '0;
    end else begin : g_dly
      logic [PE_OUT_WIDTH:0] sh_q [D];

      // Shift register; flushed to zero whenever a WS job is not running
      always_ff @(posedge clk) begin
        if (reset || !ws_run) begin
          for (int k = 0; k < int'(D); k++) sh_q[k] <= '0;
        end else begin
          sh_q[0] <= {in_v, in_d};
          for (int k = 1; k < int'(D); k++) sh_q[k] <= sh_q[k-1];
        end
      end

      assign al_valid[c] = mode_q ? (run & in_v) : sh_q[D-1][PE_OUT_WIDTH];
      assign al_data[c*PE_OUT_WIDTH +: PE_OUT_WIDTH] =
        mode_q ? (run ? in_d : '0) : sh_q[D-1][PE_OUT_WIDTH-1:0];
    end
  end

  logic             row_evt, skew_hit, pop, full, push, drop;
  logic [ROW_W-1:0] row_idx;
  logic [ENT_W-1:0] head;

  // Row classification and FIFO push/pop decisions
  always_comb begin
    row_evt  = 1'b0;
    skew_hit = 1'b0;
    if (run) begin
      row_evt  = (&al_valid) && (rows_in_q != num_rows_q);
      skew_hit = (|al_valid) && !(&al_valid);
    end
    pop     = (cnt_q != '0) && out_ready;
    full    = (cnt_q == CNT_W'(FIFO_DEPTH));
    push    = row_evt && (!full || pop);
    drop    = row_evt && full && !pop;
    row_idx = mode_q ? ROW_W'(num_rows_q - rows_in_q - ROW_W'(1)) : rows_in_q;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_rows == '0) ? S_DONE : S_RUN;
      S_RUN:   if (rows_in_q == num_rows_q) state_d = S_DRAIN;
      S_DRAIN: if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Job context, row counter and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= 1'b0;
      num_rows_q <= '0;
      rows_in_q  <= '0;
      overflow_q <= 1'b0;
      skew_err_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      mode_q     <= mode;
      num_rows_q <= num_rows;
      rows_in_q  <= '0;
      overflow_q <= 1'b0;
      skew_err_q <= 1'b0;
    end else begin
      if (row_evt)  rows_in_q  <= rows_in_q + ROW_W'(1);
      if (drop)     overflow_q <= 1'b1;
      if (skew_hit) skew_err_q <= 1'b1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage; contents are masked at the output while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {row_idx, al_data};
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_valid   = (cnt_q != '0);
  assign out_data    = out_valid ? head[DATA_W-1:0] : '0;
  assign out_row_idx = out_valid ? head[ENT_W-1:DATA_W] : '0;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign overflow    = overflow_q;
  assign skew_err    = skew_err_q;

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: WS deskew, OS tagging, overflow, skew, reset abort.
module tb_psum_collector;

  localparam int unsigned PW = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned RW = 8;
  localparam int unsigned DW = NC * PW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [RW-1:0] num_rows;
  logic [DW-1:0] col_data_in;
  logic [NC-1:0] col_valid_in;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_row_idx;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          skew_err;

  int n_checks = 0;
  int n_fail   = 0;

  psum_collector #(.PE_OUT_WIDTH(PW), .NUM_COLS(NC), .FIFO_DEPTH(4), .ROW_W(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num_rows(num_rows),
    .col_data_in(col_data_in), .col_valid_in(col_valid_in),
    .out_data(out_data), .out_row_idx(out_row_idx), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done),
    .overflow(overflow), .skew_err(skew_err)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] ws_word(input int i);
    logic [DW-1:0] w;
    for (int c = 0; c < int'(NC); c++) w[c*PW +: PW] = PW'(100 * i + c);
    return w;
  endfunction

  function automatic logic [DW-1:0] os_word(input int v);
    logic [DW-1:0] w;
    for (int c = 0; c < int'(NC); c++) w[c*PW +: PW] = PW'(v + 16 * c);
    return w;
  endfunction

  task automatic clear_cols();
    col_data_in  = '0;
    col_valid_in = '0;
  endtask

  task automatic set_col(input int c, input int i);
    col_valid_in[c]         = 1'b1;
    col_data_in[c*PW +: PW] = PW'(100 * i + c);
  endtask

  // Skewed WS stimulus: column c of row i at relative cycle i+c
  task automatic ws_inputs(input int rel, input int nrows);
    clear_cols();
    for (int c = 0; c < int'(NC); c++)
      if (rel - c >= 0 && rel - c < nrows) set_col(c, rel - c);
  endtask

  task automatic kick(input logic m, input int n);
    start    = 1'b1;
    mode     = m;
    num_rows = RW'(n);
    tick();
    start    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; num_rows = '0; out_ready = 1'b0;
    clear_cols();
    repeat (3) tick();
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst flags", {overflow, skew_err}, 0);
    reset = 1'b0;
    tick();

    // WS, 3 rows, consumer always ready
    out_ready = 1'b1;
    kick(1'b0, 3);
    for (int k = 1; k <= 12; k++) begin
      ws_inputs(k - 1, 3);
      check($sformatf("ws c%0d valid", k), out_valid, (k >= 5 && k <= 7));
      if (k >= 5 && k <= 7) begin
        check($sformatf("ws c%0d data", k), out_data, ws_word(k - 5));
        check($sformatf("ws c%0d idx", k), out_row_idx, k - 5);
      end
      check($sformatf("ws c%0d done", k), done, (k == 9));
      check($sformatf("ws c%0d busy", k), busy, (k <= 9));
      tick();
    end
    check("ws flags", {overflow, skew_err}, 0);

    // OS, 4 aligned rows, indices descend
    kick(1'b1, 4);
    for (int k = 1; k <= 8; k++) begin
      clear_cols();
      if (k <= 4) begin
        col_valid_in = '1;
        col_data_in  = os_word(k + 6);
      end
      check($sformatf("os c%0d valid", k), out_valid, (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) begin
        check($sformatf("os c%0d data", k), out_data, os_word(k + 5));
        check($sformatf("os c%0d idx", k), out_row_idx, 5 - k);
      end
      check($sformatf("os c%0d done", k), done, (k == 7));
      tick();
    end

    // Overflow: 6 WS rows into a 4-entry FIFO with the consumer stalled
    out_ready = 1'b0;
    kick(1'b0, 6);
    for (int k = 1; k <= 18; k++) begin
      ws_inputs(k - 1, 6);
      out_ready = (k >= 12);
      check($sformatf("ovf c%0d valid", k), out_valid, (k >= 5 && k <= 15));
      if (k >= 5 && k <= 15) begin
        check($sformatf("ovf c%0d idx", k), out_row_idx, (k < 12) ? 0 : k - 12);
        check($sformatf("ovf c%0d data", k), out_data, ws_word((k < 12) ? 0 : k - 12));
      end
      check($sformatf("ovf c%0d flag", k), overflow, (k >= 9));
      check($sformatf("ovf c%0d done", k), done, (k == 17));
      tick();
    end

    // Skew: column 2 of row 1 arrives a cycle late; a later good row completes the job
    out_ready = 1'b1;
    kick(1'b0, 2);
    for (int k = 1; k <= 12; k++) begin
      clear_cols();
      if (k >= 1 && k <= 4) set_col(k - 1, 0);
      if (k == 2) set_col(0, 1);
      if (k == 3) set_col(1, 1);
      if (k == 5) begin set_col(2, 1); set_col(3, 1); end
      if (k >= 5 && k <= 8) set_col(k - 5, 4);
      if (k == 1) check("skew ovf cleared", overflow, 0);
      check($sformatf("skew c%0d flag", k), skew_err, (k >= 6));
      check($sformatf("skew c%0d valid", k), out_valid, (k == 5 || k == 9));
      if (k == 5) check("skew row0 data", out_data, ws_word(0));
      if (k == 9) begin
        check("skew row1 data", out_data, ws_word(4));
        check("skew row1 idx", out_row_idx, 1);
      end
      check($sformatf("skew c%0d done", k), done, (k == 11));
      check($sformatf("skew c%0d busy", k), busy, (k <= 11));
      tick();
    end

    // Reset mid-job with two rows queued
    out_ready = 1'b0;
    kick(1'b0, 4);
    for (int k = 1; k <= 6; k++) begin
      ws_inputs(k - 1, 2);
      if (k == 6) check("abort queued", out_valid, 1);
      if (k == 6) reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    clear_cols();
    check("abort out_valid", out_valid, 0);
    check("abort out_data", out_data, 0);
    check("abort idx", out_row_idx, 0);
    check("abort busy", busy, 0);
    check("abort flags", {done, overflow, skew_err}, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("abort no done %0d", k), {busy, done}, 0);
    end

    // Zero-row job goes straight to DONE
    kick(1'b0, 0);
    check("zero busy", busy, 1);
    check("zero done", done, 1);
    check("zero no write", out_valid, 0);
    tick();
    check("zero after", {busy, done, out_valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
